// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

   typedef enum logic [2:0] {
      RUN         = 3'd0,
      MISS_REFILL = 3'd1,
      MISS_RETRY  = 3'd2,
      DRAIN       = 3'd3,
      HALTED      = 3'd4
   } hz_state_t;

   localparam logic [4:0]  REG_ZERO      = 5'd0;
   localparam int unsigned MEM_LAT_DEF   = 4;
   localparam int unsigned DRAIN_CYC_DEF = 3;
   localparam int unsigned CNT_W_DEF     = 32;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst_b,
   input  logic             clear,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   always_ff @(posedge clk) begin
      if (!rst_b || clear) begin
         count <= '0;
      end else if (inc && (count != {CNT_W{1'b1}})) begin
         count <= count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, branch
// squash, D-cache refill sequencing, halt drain and stall/miss counters.
module pipeline_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned MEM_LAT   = MEM_LAT_DEF,
   parameter int unsigned DRAIN_CYC = DRAIN_CYC_DEF,
   parameter int unsigned CNT_W     = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst_b,
   input  logic [4:0]       rs_num_id,
   input  logic [4:0]       rt_num_id,
   input  logic             rs_used_id,
   input  logic             rt_used_id,
   input  logic             mem_read_exe,
   input  logic [4:0]       rd_num_exe,
   input  logic             ctrl_taken_id,
   input  logic             halt_id,
   input  logic             cache_en_mem,
   input  logic             hit_mem,
   output logic             pc_hold,
   output logic             freeze_if_id,
   output logic             freeze_id_exe,
   output logic             freeze_exe_mem,
   output logic             freeze_mem_wb,
   output logic             flush_if_id,
   output logic             bubble_id_exe,
   output logic             refill_req,
   output logic             refill_we,
   output logic             halted,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] miss_count
);

   localparam int unsigned LAT_W   = 4;
   localparam int unsigned DRAIN_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

   hz_state_t          state, state_nxt;
   hz_state_t          ret_state, ret_state_nxt;
   logic [LAT_W-1:0]   lat_cnt, lat_cnt_nxt;
   logic [DRAIN_W-1:0] drain_cnt, drain_cnt_nxt;
   logic               lu, miss, miss_inc, stall_inc;

   // Load-use: EXE load targets a non-zero register the ID instruction reads.
   assign lu = mem_read_exe && (rd_num_exe != REG_ZERO) &&
               ((rs_used_id && (rs_num_id == rd_num_exe)) ||
                (rt_used_id && (rt_num_id == rd_num_exe)));
   assign miss = cache_en_mem && !hit_mem;

   always_ff @(posedge clk) begin
      if (!rst_b) begin
         state     <= RUN;
         ret_state <= RUN;
         lat_cnt   <= '0;
         drain_cnt <= '0;
      end else begin
         state     <= state_nxt;
         ret_state <= ret_state_nxt;
         lat_cnt   <= lat_cnt_nxt;
         drain_cnt <= drain_cnt_nxt;
      end
   end

   always_comb begin
      state_nxt      = state;
      ret_state_nxt  = ret_state;
      lat_cnt_nxt    = lat_cnt;
      drain_cnt_nxt  = drain_cnt;
      pc_hold        = 1'b0;
      freeze_if_id   = 1'b0;
      freeze_id_exe  = 1'b0;
      freeze_exe_mem = 1'b0;
      freeze_mem_wb  = 1'b0;
      flush_if_id    = 1'b0;
      bubble_id_exe  = 1'b0;
      refill_req     = 1'b0;
      refill_we      = 1'b0;
      halted         = 1'b0;
      miss_inc       = 1'b0;

      unique case (state)
         RUN: begin
            if (miss) begin
               // Freezing ID defers any lu/branch until the access completes.
               {pc_hold, freeze_if_id, freeze_id_exe, freeze_exe_mem, freeze_mem_wb} = '1;
               miss_inc      = 1'b1;
               ret_state_nxt = RUN;
               lat_cnt_nxt   = '0;
               state_nxt     = MISS_REFILL;
            end else if (lu) begin
               pc_hold       = 1'b1;
               freeze_if_id  = 1'b1;
               bubble_id_exe = 1'b1;
            end else if (halt_id) begin
               pc_hold       = 1'b1;
               flush_if_id   = 1'b1;
               drain_cnt_nxt = '0;
               state_nxt     = DRAIN;
            end else if (ctrl_taken_id) begin
               flush_if_id = 1'b1;
            end
         end
         MISS_REFILL: begin
            {pc_hold, freeze_if_id, freeze_id_exe, freeze_exe_mem, freeze_mem_wb} = '1;
            refill_req  = 1'b1;
            lat_cnt_nxt = lat_cnt + LAT_W'(1);
            if (lat_cnt == LAT_W'(MEM_LAT - 1)) begin
               refill_we = 1'b1;
               state_nxt = MISS_RETRY;
            end
         end
         MISS_RETRY: begin
            {pc_hold, freeze_if_id, freeze_id_exe, freeze_exe_mem, freeze_mem_wb} = '1;
            if (miss) begin
               lat_cnt_nxt = '0;
               state_nxt   = MISS_REFILL;
            end else begin
               state_nxt = ret_state;
            end
         end
         DRAIN: begin
            if (miss) begin
               {pc_hold, freeze_if_id, freeze_id_exe, freeze_exe_mem, freeze_mem_wb} = '1;
               miss_inc      = 1'b1;
               ret_state_nxt = DRAIN;
               lat_cnt_nxt   = '0;
               state_nxt     = MISS_REFILL;
            end else begin
               pc_hold       = 1'b1;
               freeze_if_id  = 1'b1;
               bubble_id_exe = 1'b1;
               drain_cnt_nxt = drain_cnt + DRAIN_W'(1);
               if (drain_cnt == DRAIN_W'(DRAIN_CYC - 1)) begin
                  state_nxt = HALTED;
               end
            end
         end
         HALTED: begin
            {pc_hold, freeze_if_id, freeze_id_exe, freeze_exe_mem, freeze_mem_wb} = '1;
            halted = 1'b1;
         end
         default: begin
            state_nxt = RUN;
         end
      endcase
   end

   assign stall_inc = pc_hold && (state != HALTED);

   sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst_b (rst_b),
      .clear (1'b0),
      .inc   (stall_inc),
      .count (stall_cycles)
   );

   sat_counter #(.CNT_W(CNT_W)) u_miss_cnt (
      .clk   (clk),
      .rst_b (rst_b),
      .clear (1'b0),
      .inc   (miss_inc),
      .count (miss_count)
   );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: single-cycle RUN vector table plus
// hand sequences for refill, retry-miss, reset mid-refill and halt drain.
module tb_pipeline_hazard_ctrl;

   logic        clk = 1'b0;
   logic        rst_b;
   logic [4:0]  rs_num_id, rt_num_id, rd_num_exe;
   logic        rs_used_id, rt_used_id, mem_read_exe;
   logic        ctrl_taken_id, halt_id, cache_en_mem, hit_mem;
   logic        pc_hold, freeze_if_id, freeze_id_exe, freeze_exe_mem, freeze_mem_wb;
   logic        flush_if_id, bubble_id_exe, refill_req, refill_we, halted;
   logic [31:0] stall_cycles, miss_count;

   always #5 clk = ~clk;

   pipeline_hazard_ctrl #(.MEM_LAT(4), .DRAIN_CYC(3), .CNT_W(32)) dut (
      .clk            (clk),
      .rst_b          (rst_b),
      .rs_num_id      (rs_num_id),
      .rt_num_id      (rt_num_id),
      .rs_used_id     (rs_used_id),
      .rt_used_id     (rt_used_id),
      .mem_read_exe   (mem_read_exe),
      .rd_num_exe     (rd_num_exe),
      .ctrl_taken_id  (ctrl_taken_id),
      .halt_id        (halt_id),
      .cache_en_mem   (cache_en_mem),
      .hit_mem        (hit_mem),
      .pc_hold        (pc_hold),
      .freeze_if_id   (freeze_if_id),
      .freeze_id_exe  (freeze_id_exe),
      .freeze_exe_mem (freeze_exe_mem),
      .freeze_mem_wb  (freeze_mem_wb),
      .flush_if_id    (flush_if_id),
      .bubble_id_exe  (bubble_id_exe),
      .refill_req     (refill_req),
      .refill_we      (refill_we),
      .halted         (halted),
      .stall_cycles   (stall_cycles),
      .miss_count     (miss_count)
   );

   // Output vector bits: pc_hold, fz_if_id, fz_id_exe, fz_exe_mem, fz_mem_wb,
   // flush_if_id, bubble_id_exe, refill_req, refill_we, halted.
   localparam logic [9:0] O_NONE   = 10'b0000000000;
   localparam logic [9:0] O_LU     = 10'b1100001000;
   localparam logic [9:0] O_FLUSH  = 10'b0000010000;
   localparam logic [9:0] O_HALTID = 10'b1000010000;
   localparam logic [9:0] O_MISS   = 10'b1111100000;
   localparam logic [9:0] O_REF    = 10'b1111100100;
   localparam logic [9:0] O_REFWE  = 10'b1111100110;
   localparam logic [9:0] O_HALTED = 10'b1111100001;

   typedef struct packed {
      logic [4:0] rs;
      logic [4:0] rt;
      logic       rs_u;
      logic       rt_u;
      logic       mrd;
      logic [4:0] rd;
      logic       ctrl;
      logic       halt;
      logic       cen;
      logic       hit;
      logic [9:0] exp;
   } vec_t;

   vec_t vecs [12];
   int   n_cmp = 0;
   int   n_err = 0;
   int   exp_stall = 0;
   int   exp_miss = 0;

   function automatic logic [9:0] outs();
      return {pc_hold, freeze_if_id, freeze_id_exe, freeze_exe_mem, freeze_mem_wb,
              flush_if_id, bubble_id_exe, refill_req, refill_we, halted};
   endfunction

   task automatic quiet();
      rs_num_id = 5'd0; rt_num_id = 5'd0; rd_num_exe = 5'd0;
      rs_used_id = 1'b0; rt_used_id = 1'b0; mem_read_exe = 1'b0;
      ctrl_taken_id = 1'b0; halt_id = 1'b0; cache_en_mem = 1'b0; hit_mem = 1'b0;
   endtask

   task automatic apply(input vec_t v);
      rs_num_id = v.rs; rt_num_id = v.rt; rs_used_id = v.rs_u; rt_used_id = v.rt_u;
      mem_read_exe = v.mrd; rd_num_exe = v.rd; ctrl_taken_id = v.ctrl;
      halt_id = v.halt; cache_en_mem = v.cen; hit_mem = v.hit;
   endtask

   // One clock: check outputs mid-cycle, update counter model, advance.
   task automatic cyc(input string name, input logic [9:0] exp, input bit miss_start);
      @(negedge clk);
      n_cmp++;
      if (outs() !== exp) begin
         n_err++;
         $display("FAIL %s: outputs got %b expected %b", name, outs(), exp);
      end
      if (exp[9] && !exp[0]) exp_stall++;
      if (miss_start) exp_miss++;
      @(posedge clk); #1;
   endtask

   // Quiet cycle that checks both counters against the model.
   task automatic chk_cnt(input string name);
      quiet();
      @(negedge clk);
      n_cmp++;
      if (stall_cycles !== 32'(exp_stall)) begin
         n_err++;
         $display("FAIL %s stall_cycles: got %0d expected %0d", name, stall_cycles, exp_stall);
      end
      n_cmp++;
      if (miss_count !== 32'(exp_miss)) begin
         n_err++;
         $display("FAIL %s miss_count: got %0d expected %0d", name, miss_count, exp_miss);
      end
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      quiet();
      rst_b = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_b = 1'b1;
      exp_stall = 0;
      exp_miss  = 0;
   endtask

   initial begin
      //           rs    rt    rsu   rtu   mrd   rd    ctrl  halt  cen   hit   exp
      vecs[0]  = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, O_NONE};
      vecs[1]  = '{5'd8, 5'd3, 1'b1, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0, O_LU};
      vecs[2]  = '{5'd2, 5'd8, 1'b1, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0, O_LU};
      vecs[3]  = '{5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, O_NONE};
      vecs[4]  = '{5'd8, 5'd8, 1'b0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0, O_NONE};
      vecs[5]  = '{5'd8, 5'd3, 1'b1, 1'b1, 1'b0, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0, O_NONE};
      vecs[6]  = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, O_FLUSH};
      vecs[7]  = '{5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, O_LU};
      vecs[8]  = '{5'd8, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, O_FLUSH};
      vecs[9]  = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, O_NONE};
      vecs[10] = '{5'd9, 5'd1, 1'b1, 1'b1, 1'b1, 5'd9, 1'b0, 1'b1, 1'b0, 1'b0, O_LU};
      vecs[11] = '{5'd7, 5'd6, 1'b1, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, O_NONE};

      do_reset();
      cyc("reset_outputs", O_NONE, 1'b0);
      chk_cnt("reset");

      for (int i = 0; i < 12; i++) begin
         apply(vecs[i]);
         cyc($sformatf("vec%0d", i), vecs[i].exp, 1'b0);
      end
      chk_cnt("table");

      // Miss with lu present: miss wins, four refill cycles, one retry.
      quiet();
      cache_en_mem = 1'b1; mem_read_exe = 1'b1; rd_num_exe = 5'd8;
      rs_num_id = 5'd8; rs_used_id = 1'b1;
      cyc("miss_detect", O_MISS, 1'b1);
      for (int i = 1; i <= 3; i++) cyc($sformatf("refill%0d", i), O_REF, 1'b0);
      cyc("refill4_we", O_REFWE, 1'b0);
      hit_mem = 1'b1;
      cyc("retry", O_MISS, 1'b0);
      cache_en_mem = 1'b0;
      cyc("lu_after_refill", O_LU, 1'b0);
      chk_cnt("miss");

      // Retry still misses: refill again without a second miss count.
      quiet();
      cache_en_mem = 1'b1;
      cyc("m2_detect", O_MISS, 1'b1);
      for (int i = 1; i <= 3; i++) cyc($sformatf("m2_refill%0d", i), O_REF, 1'b0);
      cyc("m2_refill4_we", O_REFWE, 1'b0);
      cyc("m2_retry_miss", O_MISS, 1'b0);
      for (int i = 1; i <= 3; i++) cyc($sformatf("m2_rerefill%0d", i), O_REF, 1'b0);
      cyc("m2_rerefill4_we", O_REFWE, 1'b0);
      hit_mem = 1'b1;
      cyc("m2_retry_hit", O_MISS, 1'b0);
      cache_en_mem = 1'b0; hit_mem = 1'b0;
      cyc("m2_run", O_NONE, 1'b0);
      chk_cnt("miss_retry");

      // Reset asserted in the second refill cycle.
      quiet();
      cache_en_mem = 1'b1;
      cyc("rr_detect", O_MISS, 1'b1);
      cyc("rr_refill1", O_REF, 1'b0);
      rst_b = 1'b0;
      @(posedge clk); #1;
      rst_b = 1'b1;
      quiet();
      exp_stall = 0;
      exp_miss  = 0;
      cyc("rr_after_reset", O_NONE, 1'b0);
      chk_cnt("rr");

      // Halt, miss on the last drain cycle, drain resumes with one cycle left.
      quiet();
      halt_id = 1'b1;
      cyc("halt_id", O_HALTID, 1'b0);
      halt_id = 1'b0;
      cyc("drain0", O_LU, 1'b0);
      cyc("drain1", O_LU, 1'b0);
      cache_en_mem = 1'b1;
      cyc("drain_miss", O_MISS, 1'b1);
      for (int i = 1; i <= 3; i++) cyc($sformatf("d_refill%0d", i), O_REF, 1'b0);
      cyc("d_refill4_we", O_REFWE, 1'b0);
      hit_mem = 1'b1;
      cyc("d_retry", O_MISS, 1'b0);
      cache_en_mem = 1'b0; hit_mem = 1'b0;
      cyc("drain_last", O_LU, 1'b0);
      cyc("halted0", O_HALTED, 1'b0);
      halt_id = 1'b1; ctrl_taken_id = 1'b1; cache_en_mem = 1'b1;
      cyc("halted_busy", O_HALTED, 1'b0);
      quiet();
      cyc("halted_sticky", O_HALTED, 1'b0);
      chk_cnt("halted");

      do_reset();
      cyc("post_halt_reset", O_NONE, 1'b0);
      chk_cnt("post_halt_reset");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
